// File: rtl/bch_pkg.sv
// Shared types and default constants for the BCH(15,7) encoder family.
package bch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int         BCH_K        = 7;
  localparam int         BCH_N        = 15;
  localparam logic [8:0] BCH_GEN_POLY = 9'h1D1;

  // Counter width that never collapses to zero bits, even for a 1-bit message.
  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/bch_parity_lfsr.sv
// Bit-serial division LFSR: accumulates the remainder of m(x)*x^P modulo g(x).
// The syndrome/decoder blocks reuse it.
module bch_parity_lfsr #(
  parameter int         P        = 8,
  parameter logic [P:0] GEN_POLY = 9'h1D1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  output logic [P-1:0] parity,
  output logic [P-1:0] parity_next
);

  logic fb;

  // One division step: feedback from the top remainder bit folds g(x) back in.
  always_comb begin
    fb          = bit_in ^ parity[P-1];
    parity_next = (parity << 1) ^ (fb ? GEN_POLY[P-1:0] : '0);
  end

  // The remainder register is cleared at frame start and advances only when enabled.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      parity <= '0;
    end else if (en) begin
      parity <= parity_next;
    end
  end

endmodule

// File: rtl/bch_encoder_stream.sv
// Systematic BCH/cyclic encoder with valid/ready on both sides.
// It takes one K-bit message, shifts it MSB-first through the parity LFSR and
// holds the N-bit codeword until the consumer accepts it.
module bch_encoder_stream
  import bch_pkg::*;
#(
  parameter int             K        = BCH_K,
  parameter int             N        = BCH_N,
  parameter logic [N-K:0]   GEN_POLY = BCH_GEN_POLY
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [K-1:0] msg_data,
  output logic         cw_valid,
  input  logic         cw_ready,
  output logic [N-1:0] cw_data,
  output logic         busy
);

  localparam int P  = N - K;
  localparam int CW = clog2_min1(K);

  if (N <= K || !GEN_POLY[N-K] || !GEN_POLY[0]) begin : g_bad_params
    $fatal(1, "bch_encoder_stream: need N>K and g(x) with leading and constant terms set");
  end

  state_t         state;
  state_t         state_next;
  logic [K-1:0]   msg_sr;
  logic [K-1:0]   msg_rot;
  logic [CW-1:0]  count;
  logic [P-1:0]   parity;
  logic [P-1:0]   parity_next;
  logic           accept;
  logic           shifting;

  assign accept   = msg_valid && msg_ready;
  assign shifting = (state == SHIFT);
  assign cw_valid = (state == DONE);

  // Rotating instead of shifting means that after K steps the register holds the
  // original message again, so no separate copy of the message is kept.
  assign msg_rot = (msg_sr << 1) | (msg_sr >> (K - 1));

  bch_parity_lfsr #(
    .P        (P),
    .GEN_POLY (GEN_POLY)
  ) u_lfsr (
    .clk         (clk),
    .reset       (reset),
    .clr         (accept),
    .en          (shifting),
    .bit_in      (msg_sr[K-1]),
    .parity      (parity),
    .parity_next (parity_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    msg_ready  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == '0) state_next = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (cw_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Message register, bit counter and codeword output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_sr  <= '0;
      count   <= '0;
      cw_data <= '0;
    end else if (accept) begin
      msg_sr <= msg_data;
      count  <= CW'(K - 1);
    end else if (shifting) begin
      msg_sr <= msg_rot;
      if (count == '0) begin
        cw_data <= {msg_rot, parity_next};
      end else begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bch_encoder_stream.sv
// Self-checking bench for bch_encoder_stream: default (15,7) instance plus a
// re-parameterised (15,5) instance, checked against polynomial long division.
module tb_bch_encoder_stream;

  localparam int          K  = 7;
  localparam int          N  = 15;
  localparam logic [31:0] G  = 32'h1D1;
  localparam int          K2 = 5;
  localparam int          N2 = 15;
  localparam logic [31:0] G2 = 32'h537;

  logic          clk = 1'b0;
  logic          reset = 1'b1;

  logic          msg_valid = 1'b0;
  logic          msg_ready;
  logic [K-1:0]  msg_data = '0;
  logic          cw_valid;
  logic          cw_ready = 1'b0;
  logic [N-1:0]  cw_data;
  logic          busy;

  logic          r_msg_valid = 1'b0;
  logic          r_msg_ready;
  logic [K2-1:0] r_msg_data = '0;
  logic          r_cw_valid;
  logic          r_cw_ready = 1'b0;
  logic [N2-1:0] r_cw_data;
  logic          r_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bch_encoder_stream dut (
    .clk       (clk),
    .reset     (reset),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_data  (msg_data),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .cw_data   (cw_data),
    .busy      (busy)
  );

  bch_encoder_stream #(
    .K        (K2),
    .N        (N2),
    .GEN_POLY (11'h537)
  ) dut2 (
    .clk       (clk),
    .reset     (reset),
    .msg_valid (r_msg_valid),
    .msg_ready (r_msg_ready),
    .msg_data  (r_msg_data),
    .cw_valid  (r_cw_valid),
    .cw_ready  (r_cw_ready),
    .cw_data   (r_cw_data),
    .busy      (r_busy)
  );

  // Remainder of v(x) modulo g(x) by schoolbook long division over GF(2).
  function automatic logic [31:0] poly_mod(input logic [31:0] v, input int n, input int p,
                                           input logic [31:0] g);
    logic [31:0] r;
    r = v;
    for (int i = n - 1; i >= p; i--) begin
      if (r[i]) r = r ^ (g << (i - p));
    end
    return r;
  endfunction

  // Systematic codeword: message in the top bits, remainder of m(x)*x^p below.
  function automatic logic [31:0] model_cw(input logic [31:0] m, input int k, input int n,
                                           input logic [31:0] g);
    int p;
    p = n - k;
    return (m << p) | poly_mod(m << p, n, p, g);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one message into the default DUT with cw_ready high; returns the
  // codeword and the number of edges from accept to cw_valid.
  task automatic encode(input logic [K-1:0] m, output logic [N-1:0] cw, output int lat);
    msg_data  = m;
    msg_valid = 1'b1;
    cw_ready  = 1'b1;
    tick();
    msg_valid = 1'b0;
    msg_data  = K'($urandom);
    lat = 0;
    while (!cw_valid && lat < 40) begin
      tick();
      lat++;
    end
    cw = cw_data;
    tick();
  endtask

  task automatic encode2(input logic [K2-1:0] m, output logic [N2-1:0] cw, output int lat);
    r_msg_data  = m;
    r_msg_valid = 1'b1;
    r_cw_ready  = 1'b1;
    tick();
    r_msg_valid = 1'b0;
    r_msg_data  = K2'($urandom);
    lat = 0;
    while (!r_cw_valid && lat < 40) begin
      tick();
      lat++;
    end
    cw = r_cw_data;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (msg_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_msg_ready: got %b expected 1", msg_ready); end
    checks++; if (cw_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_cw_valid: got %b expected 0", cw_valid); end
    checks++; if (cw_data !== '0) begin failures++; $display("[TB] FAIL reset_cw_data: got %h expected 0", cw_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [N-1:0] cw;
    int lat;
    encode(7'h01, cw, lat);
    checks++; if (lat !== K) begin failures++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, K); end
    checks++; if (cw !== 15'h01D1) begin failures++; $display("[TB] FAIL basic_cw01: got %h expected 01d1", cw); end
    checks++; if (cw_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_pulse: got %b expected 0", cw_valid); end
    checks++; if (msg_ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_ready_after: got %b expected 1", msg_ready); end
    encode(7'h7F, cw, lat);
    checks++; if (cw !== 15'h7FFF) begin failures++; $display("[TB] FAIL basic_cw7f: got %h expected 7fff", cw); end
    encode(7'h00, cw, lat);
    checks++; if (cw !== 15'h0000) begin failures++; $display("[TB] FAIL basic_cw00: got %h expected 0000", cw); end
  endtask

  task automatic test_backpressure();
    int stray;
    msg_data  = 7'h01;
    msg_valid = 1'b1;
    cw_ready  = 1'b0;
    tick();
    msg_valid = 1'b0;
    checks++; if (busy !== 1'b1 || msg_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_shift_flags: got busy=%b ready=%b expected busy=1 ready=0", busy, msg_ready); end
    for (int i = 0; i < K; i++) tick();
    for (int i = 0; i < 20; i++) begin
      checks++; if (cw_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid_hold: got %b expected 1 at cycle %0d", cw_valid, i); end
      checks++; if (cw_data !== 15'h01D1) begin failures++; $display("[TB] FAIL bp_data_hold: got %h expected 01d1 at cycle %0d", cw_data, i); end
      checks++; if (msg_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_low: got %b expected 0 at cycle %0d", msg_ready, i); end
      if (i == 5) begin msg_valid = 1'b1; msg_data = 7'h7F; end
      if (i == 7) msg_valid = 1'b0;
      tick();
    end
    cw_ready = 1'b1;
    tick();
    checks++; if (cw_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_release_valid: got %b expected 0", cw_valid); end
    checks++; if (msg_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_ready: got %b expected 1", msg_ready); end
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      if (cw_valid || !msg_ready) stray++;
      tick();
    end
    checks++; if (stray !== 0) begin failures++; $display("[TB] FAIL bp_ignored_msg: got %0d active cycles expected 0", stray); end
  endtask

  task automatic test_linearity();
    logic [N-1:0] c1, c2, c3;
    int lat;
    encode(7'h01, c1, lat);
    encode(7'h02, c2, lat);
    encode(7'h03, c3, lat);
    checks++; if (c3 !== (c1 ^ c2)) begin failures++; $display("[TB] FAIL linearity: got %h expected %h", c3, c1 ^ c2); end
    checks++; if (c2 !== N'(model_cw(32'h2, K, N, G))) begin failures++; $display("[TB] FAIL lin_cw02: got %h expected %h", c2, N'(model_cw(32'h2, K, N, G))); end
  endtask

  task automatic test_random();
    logic [N-1:0] cw;
    logic [K-1:0] m;
    int lat;
    for (int i = 0; i < 200; i++) begin
      m = K'($urandom);
      encode(m, cw, lat);
      checks++; if (lat !== K) begin failures++; $display("[TB] FAIL rand_latency: got %0d expected %0d msg %h", lat, K, m); end
      checks++; if (cw !== N'(model_cw(32'(m), K, N, G))) begin failures++; $display("[TB] FAIL rand_cw: got %h expected %h msg %h", cw, N'(model_cw(32'(m), K, N, G)), m); end
      checks++; if (poly_mod(32'(cw), N, N - K, G) !== 32'h0) begin failures++; $display("[TB] FAIL rand_divisible: got remainder %h expected 0", poly_mod(32'(cw), N, N - K, G)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] q[$];
    logic [N-1:0] exp;
    int last;
    last = -1;
    cw_ready  = 1'b1;
    msg_valid = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      msg_data = K'($urandom);
      if (cw_valid) begin
        exp = (q.size() > 0) ? q.pop_front() : '1;
        checks++; if (cw_data !== exp) begin failures++; $display("[TB] FAIL b2b_cw: got %h expected %h", cw_data, exp); end
      end
      if (msg_ready) begin
        q.push_back(N'(model_cw(32'(msg_data), K, N, G)));
        if (last >= 0) begin
          checks++; if (cyc - last !== K + 2) begin failures++; $display("[TB] FAIL b2b_period: got %0d expected %0d", cyc - last, K + 2); end
        end
        last = cyc;
      end
      tick();
    end
    msg_valid = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cw_valid) begin
        exp = (q.size() > 0) ? q.pop_front() : '1;
        checks++; if (cw_data !== exp) begin failures++; $display("[TB] FAIL b2b_drain_cw: got %h expected %h", cw_data, exp); end
      end
      tick();
    end
    checks++; if (q.size() !== 0) begin failures++; $display("[TB] FAIL b2b_outstanding: got %0d expected 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] cw;
    int lat;
    int seen;
    msg_data  = 7'h55;
    msg_valid = 1'b1;
    cw_ready  = 1'b1;
    tick();
    msg_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++; if (msg_ready !== 1'b1 || cw_valid !== 1'b0 || busy !== 1'b0 || cw_data !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got ready=%b valid=%b busy=%b data=%h expected 1 0 0 0000", msg_ready, cw_valid, busy, cw_data);
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (cw_valid) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL midreset_no_cw: got %0d valid cycles expected 0", seen); end
    encode(7'h2A, cw, lat);
    checks++; if (cw !== N'(model_cw(32'h2A, K, N, G)) || lat !== K) begin
      failures++;
      $display("[TB] FAIL midreset_next: got %h lat %0d expected %h lat %0d", cw, lat, N'(model_cw(32'h2A, K, N, G)), K);
    end
  endtask

  task automatic test_reparam();
    logic [N2-1:0] cw;
    logic [K2-1:0] m;
    int lat;
    encode2(5'h01, cw, lat);
    checks++; if (cw !== 15'h0537) begin failures++; $display("[TB] FAIL reparam_cw01: got %h expected 0537", cw); end
    checks++; if (lat !== K2) begin failures++; $display("[TB] FAIL reparam_latency: got %0d expected %0d", lat, K2); end
    for (int i = 0; i < 30; i++) begin
      m = K2'($urandom);
      encode2(m, cw, lat);
      checks++; if (cw !== N2'(model_cw(32'(m), K2, N2, G2))) begin failures++; $display("[TB] FAIL reparam_rand_cw: got %h expected %h msg %h", cw, N2'(model_cw(32'(m), K2, N2, G2)), m); end
      checks++; if (poly_mod(32'(cw), N2, N2 - K2, G2) !== 32'h0) begin failures++; $display("[TB] FAIL reparam_divisible: got remainder %h expected 0", poly_mod(32'(cw), N2, N2 - K2, G2)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_linearity();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_reparam();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
